// File: rtl/umi_tx_ser_pkg.sv
// umi_tx_ser_pkg: shared link beat-flag encoding, FSM states and beat-count helper
package umi_tx_ser_pkg;
  localparam int FLAG_FIRST = 0;
  localparam int FLAG_LAST  = 1;
  localparam int FLAG_BURST = 2;
  localparam int FLAG_W     = 3;
  typedef enum logic {IDLE, SEND} state_e;
  function automatic int beats(input int uw, input int lw);
    return uw / lw;
  endfunction
endpackage

// File: rtl/umi_tx_ser_if.sv
// umi_tx_ser_if: packer-side and link-side handshake bundle of the serializer
interface umi_tx_ser_if #(parameter int UW = 256, parameter int LW = 64);
  logic          umi_in_valid;
  logic          umi_in_ready;
  logic [UW-1:0] umi_in_packet;
  logic          umi_in_burst;
  logic          phy_out_valid;
  logic          phy_out_ready;
  logic [LW-1:0] phy_out_data;
  logic          phy_out_first;
  logic          phy_out_last;
  logic          phy_out_burst;
  logic          busy;
  modport master(output umi_in_valid, umi_in_packet, umi_in_burst, phy_out_ready,
                 input umi_in_ready, phy_out_valid, phy_out_data, phy_out_first,
                 phy_out_last, phy_out_burst, busy);
  modport slave(input umi_in_valid, umi_in_packet, umi_in_burst, phy_out_ready,
                output umi_in_ready, phy_out_valid, phy_out_data, phy_out_first,
                phy_out_last, phy_out_burst, busy);
endinterface

// File: rtl/umi_tx_ser.sv
// umi_tx_ser: streams one UW-bit packet as UW/LW link beats, LSB beat first, no bubbles between packets
module umi_tx_ser
  import umi_tx_ser_pkg::*;
#(
  parameter int UW = 256,
  parameter int LW = 64
) (
  input logic         clk,
  input logic         reset,
  umi_tx_ser_if.slave u
);
  localparam int NB = beats(UW, LW);
  localparam int CW = $clog2(NB);
  state_e          state;
  logic [CW-1:0]   beat_cnt;
  logic [UW-1:0]   hold;
  logic            burst;
  logic            last_beat;
  logic [FLAG_W-1:0] flags;
  assign last_beat = beat_cnt == CW'(NB - 1);
  // Sideband flags in link encoding, all gated by SEND
  always_comb begin
    flags = '0;
    flags[FLAG_FIRST] = state == SEND && beat_cnt == '0;
    flags[FLAG_LAST]  = state == SEND && last_beat;
    flags[FLAG_BURST] = state == SEND && burst;
  end
  assign u.umi_in_ready  = state == IDLE || (state == SEND && last_beat && u.phy_out_ready);
  assign u.phy_out_valid = state == SEND;
  assign u.phy_out_data  = hold[LW-1:0];
  assign u.phy_out_first = flags[FLAG_FIRST];
  assign u.phy_out_last  = flags[FLAG_LAST];
  assign u.phy_out_burst = flags[FLAG_BURST];
  assign u.busy          = state == SEND;
  // Load on input handshake (also on the last beat, for zero-bubble chaining), else shift out accepted beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      hold     <= '0;
      burst    <= 1'b0;
    end else if (u.umi_in_valid && u.umi_in_ready) begin
      state    <= SEND;
      beat_cnt <= '0;
      hold     <= u.umi_in_packet;
      burst    <= u.umi_in_burst;
    end else if (state == SEND && u.phy_out_ready) begin
      state    <= last_beat ? IDLE : SEND;
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      hold     <= hold >> LW;
    end
  end
endmodule

// File: tb/tb_umi_tx_ser.sv
// tb_umi_tx_ser: directed and scoreboarded checks of the serializer at LW=64, 32 and 128
module tb_umi_tx_ser;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vec = 0;
  int errs = 0;
  logic [255:0] pa, pb, pc;
  bit sel = 1'b0;
  logic s_valid = 1'b0, s_burst = 1'b0, s_pready = 1'b0;
  logic [255:0] s_packet = '0;
  logic s_iready, s_ovalid, s_first, s_last, s_oburst;
  logic [127:0] s_odata;
  always #5 clk = ~clk;
  umi_tx_ser_if #(.UW(256), .LW(64))  i64();
  umi_tx_ser_if #(.UW(256), .LW(32))  i32();
  umi_tx_ser_if #(.UW(256), .LW(128)) i128();
  umi_tx_ser #(.UW(256), .LW(64))  dut   (.clk(clk), .reset(reset), .u(i64));
  umi_tx_ser #(.UW(256), .LW(32))  dut32 (.clk(clk), .reset(reset), .u(i32));
  umi_tx_ser #(.UW(256), .LW(128)) dut128(.clk(clk), .reset(reset), .u(i128));
  assign i32.umi_in_valid   = s_valid & ~sel;
  assign i128.umi_in_valid  = s_valid & sel;
  assign i32.umi_in_packet  = s_packet;
  assign i128.umi_in_packet = s_packet;
  assign i32.umi_in_burst   = s_burst;
  assign i128.umi_in_burst  = s_burst;
  assign i32.phy_out_ready  = s_pready;
  assign i128.phy_out_ready = s_pready;
  assign s_iready = sel ? i128.umi_in_ready : i32.umi_in_ready;
  assign s_ovalid = sel ? i128.phy_out_valid : i32.phy_out_valid;
  assign s_first  = sel ? i128.phy_out_first : i32.phy_out_first;
  assign s_last   = sel ? i128.phy_out_last : i32.phy_out_last;
  assign s_oburst = sel ? i128.phy_out_burst : i32.phy_out_burst;
  assign s_odata  = sel ? i128.phy_out_data : 128'(i32.phy_out_data);

  task automatic test_reset();
    i64.umi_in_valid = 1'b1; i64.umi_in_packet = pa; i64.umi_in_burst = 1'b1; i64.phy_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (i64.phy_out_valid !== 1'b0) begin errs++; $display("FAIL rst_hold_valid: got %b want 0", i64.phy_out_valid); end
    reset = 1'b0; i64.umi_in_valid = 1'b0;
    @(negedge clk);
    vec++; if (i64.umi_in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", i64.umi_in_ready); end
    vec++; if (i64.phy_out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", i64.phy_out_valid); end
    vec++; if (i64.phy_out_first !== 1'b0) begin errs++; $display("FAIL rst_first: got %b want 0", i64.phy_out_first); end
    vec++; if (i64.phy_out_last !== 1'b0) begin errs++; $display("FAIL rst_last: got %b want 0", i64.phy_out_last); end
    vec++; if (i64.phy_out_burst !== 1'b0) begin errs++; $display("FAIL rst_burst: got %b want 0", i64.phy_out_burst); end
    vec++; if (i64.phy_out_data !== 64'h0) begin errs++; $display("FAIL rst_data: got %h want 0", i64.phy_out_data); end
    vec++; if (i64.busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", i64.busy); end
  endtask

  task automatic test_single();
    @(negedge clk);
    i64.umi_in_valid = 1'b1; i64.umi_in_packet = pa; i64.umi_in_burst = 1'b0; i64.phy_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) i64.umi_in_valid = 1'b0;
      vec++; if (i64.phy_out_valid !== 1'b1) begin errs++; $display("FAIL single_valid%0d: got %b want 1", k, i64.phy_out_valid); end
      vec++; if (i64.phy_out_data !== pa[64*k +: 64]) begin errs++; $display("FAIL single_data%0d: got %h want %h", k, i64.phy_out_data, pa[64*k +: 64]); end
      vec++; if (i64.phy_out_first !== (k == 0)) begin errs++; $display("FAIL single_first%0d: got %b want %b", k, i64.phy_out_first, k == 0); end
      vec++; if (i64.phy_out_last !== (k == 3)) begin errs++; $display("FAIL single_last%0d: got %b want %b", k, i64.phy_out_last, k == 3); end
      vec++; if (i64.busy !== 1'b1) begin errs++; $display("FAIL single_busy%0d: got %b want 1", k, i64.busy); end
    end
    @(negedge clk);
    vec++; if (i64.phy_out_valid !== 1'b0) begin errs++; $display("FAIL single_end_valid: got %b want 0", i64.phy_out_valid); end
    vec++; if (i64.busy !== 1'b0) begin errs++; $display("FAIL single_end_busy: got %b want 0", i64.busy); end
    vec++; if (i64.umi_in_ready !== 1'b1) begin errs++; $display("FAIL single_end_ready: got %b want 1", i64.umi_in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] want;
    i64.umi_in_valid = 1'b1; i64.umi_in_packet = pa; i64.umi_in_burst = 1'b0; i64.phy_out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      want = j < 4 ? pa[64*j +: 64] : pb[64*(j-4) +: 64];
      vec++; if (i64.phy_out_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid%0d: got %b want 1", j, i64.phy_out_valid); end
      vec++; if (i64.phy_out_data !== want) begin errs++; $display("FAIL b2b_data%0d: got %h want %h", j, i64.phy_out_data, want); end
      vec++; if (i64.phy_out_burst !== (j >= 4)) begin errs++; $display("FAIL b2b_burst%0d: got %b want %b", j, i64.phy_out_burst, j >= 4); end
      vec++; if (i64.umi_in_ready !== (j % 4 == 3)) begin errs++; $display("FAIL b2b_ready%0d: got %b want %b", j, i64.umi_in_ready, j % 4 == 3); end
      vec++; if (i64.phy_out_first !== (j % 4 == 0)) begin errs++; $display("FAIL b2b_first%0d: got %b want %b", j, i64.phy_out_first, j % 4 == 0); end
      if (j == 0) begin i64.umi_in_packet = pb; i64.umi_in_burst = 1'b1; end
      if (j == 4) i64.umi_in_valid = 1'b0;
    end
    @(negedge clk);
    vec++; if (i64.phy_out_valid !== 1'b0) begin errs++; $display("FAIL b2b_end_valid: got %b want 0", i64.phy_out_valid); end
  endtask

  task automatic test_backpressure();
    i64.umi_in_valid = 1'b1; i64.umi_in_packet = pa; i64.umi_in_burst = 1'b0; i64.phy_out_ready = 1'b1;
    @(negedge clk); i64.umi_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vec++; if (i64.phy_out_data !== pa[128 +: 64]) begin errs++; $display("FAIL bp_d2: got %h want %h", i64.phy_out_data, pa[128 +: 64]); end
    i64.phy_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vec++; if (i64.phy_out_data !== pa[128 +: 64]) begin errs++; $display("FAIL bp_hold_data%0d: got %h want %h", c, i64.phy_out_data, pa[128 +: 64]); end
      vec++; if (dut.beat_cnt !== 2'd2) begin errs++; $display("FAIL bp_hold_cnt%0d: got %0d want 2", c, dut.beat_cnt); end
      vec++; if (i64.phy_out_valid !== 1'b1) begin errs++; $display("FAIL bp_hold_valid%0d: got %b want 1", c, i64.phy_out_valid); end
      vec++; if (i64.umi_in_ready !== 1'b0) begin errs++; $display("FAIL bp_hold_ready%0d: got %b want 0", c, i64.umi_in_ready); end
    end
    i64.phy_out_ready = 1'b1;
    @(negedge clk);
    vec++; if (i64.phy_out_data !== pa[192 +: 64]) begin errs++; $display("FAIL bp_d3: got %h want %h", i64.phy_out_data, pa[192 +: 64]); end
    vec++; if (i64.phy_out_last !== 1'b1) begin errs++; $display("FAIL bp_last: got %b want 1", i64.phy_out_last); end
    vec++; if (i64.umi_in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_last: got %b want 1", i64.umi_in_ready); end
    @(negedge clk);
    vec++; if (i64.phy_out_valid !== 1'b0) begin errs++; $display("FAIL bp_end_valid: got %b want 0", i64.phy_out_valid); end
  endtask

  task automatic test_reset_mid();
    i64.umi_in_valid = 1'b1; i64.umi_in_packet = pa; i64.umi_in_burst = 1'b1; i64.phy_out_ready = 1'b1;
    @(negedge clk); i64.umi_in_valid = 1'b0;
    @(negedge clk);
    vec++; if (i64.phy_out_data !== pa[64 +: 64]) begin errs++; $display("FAIL rm_d1: got %h want %h", i64.phy_out_data, pa[64 +: 64]); end
    reset = 1'b1;
    #1;
    vec++; if (i64.phy_out_valid !== 1'b0) begin errs++; $display("FAIL rm_async_valid: got %b want 0", i64.phy_out_valid); end
    vec++; if (i64.phy_out_burst !== 1'b0) begin errs++; $display("FAIL rm_async_burst: got %b want 0", i64.phy_out_burst); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    vec++; if (i64.phy_out_valid !== 1'b0) begin errs++; $display("FAIL rm_after_valid: got %b want 0", i64.phy_out_valid); end
    i64.umi_in_valid = 1'b1; i64.umi_in_packet = pc; i64.umi_in_burst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) i64.umi_in_valid = 1'b0;
      vec++; if (i64.phy_out_data !== pc[64*k +: 64]) begin errs++; $display("FAIL rm_c_data%0d: got %h want %h", k, i64.phy_out_data, pc[64*k +: 64]); end
      vec++; if (i64.phy_out_first !== (k == 0)) begin errs++; $display("FAIL rm_c_first%0d: got %b want %b", k, i64.phy_out_first, k == 0); end
    end
    @(negedge clk);
    vec++; if (i64.phy_out_valid !== 1'b0) begin errs++; $display("FAIL rm_end_valid: got %b want 0", i64.phy_out_valid); end
  endtask

  task automatic test_sweep(input bit w, input int lw, input int nb, input int npk);
    logic [255:0] exp_q[$];
    logic exb_q[$];
    logic [255:0] asm;
    logic [127:0] mask;
    bit acc;
    int bi, sent, got, cyc;
    sel = w; s_valid = 1'b0; asm = '0; bi = 0; sent = 0; got = 0; cyc = 0;
    mask = (128'(1) << lw) - 128'(1);
    @(negedge clk);
    while (got < npk && cyc < 4000) begin
      cyc++;
      if (!s_valid && sent < npk && $urandom_range(0, 3) != 0) begin
        s_valid = 1'b1;
        s_packet = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        s_burst = 1'($urandom_range(0, 1));
      end
      s_pready = ($urandom_range(0, 3) != 0);
      #1;
      if (s_ovalid && s_pready) begin
        if (exp_q.size() == 0) begin
          vec++; errs++; $display("FAIL sweep%0d_spurious: got beat %h want none", lw, s_odata);
        end else begin
          vec++; if (s_first !== (bi == 0)) begin errs++; $display("FAIL sweep%0d_first: got %b want %b", lw, s_first, bi == 0); end
          vec++; if (s_last !== (bi == nb - 1)) begin errs++; $display("FAIL sweep%0d_last: got %b want %b", lw, s_last, bi == nb - 1); end
          vec++; if (s_oburst !== exb_q[0]) begin errs++; $display("FAIL sweep%0d_burst: got %b want %b", lw, s_oburst, exb_q[0]); end
          asm = asm | (256'(s_odata & mask) << (lw * bi));
          if (bi == nb - 1) begin
            vec++; if (asm !== exp_q[0]) begin errs++; $display("FAIL sweep%0d_pkt%0d: got %h want %h", lw, got, asm, exp_q[0]); end
            void'(exp_q.pop_front()); void'(exb_q.pop_front());
            got++; bi = 0; asm = '0;
          end else bi++;
        end
      end
      acc = s_valid && s_iready;
      if (acc) begin exp_q.push_back(s_packet); exb_q.push_back(s_burst); sent++; end
      @(negedge clk);
      if (acc) s_valid = 1'b0;
    end
    vec++; if (got != npk) begin errs++; $display("FAIL sweep%0d_timeout: got %0d packets want %0d", lw, got, npk); end
    s_valid = 1'b0; s_pready = 1'b0;
  endtask

  initial begin
    pa = {64'hA3A3A3A3_00000003, 64'hA2A2A2A2_00000002, 64'hA1A1A1A1_00000001, 64'hA0A0A0A0_00000000};
    pb = {64'hB3B3B3B3_0000B003, 64'hB2B2B2B2_0000B002, 64'hB1B1B1B1_0000B001, 64'hB0B0B0B0_0000B000};
    pc = {64'hC3C3C3C3_C0C0C003, 64'hC2C2C2C2_C0C0C002, 64'hC1C1C1C1_C0C0C001, 64'hC0C0C0C0_C0C0C000};
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_sweep(1'b0, 32, 8, 20);
    test_sweep(1'b1, 128, 2, 20);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
